// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared defaults for the UART receive path (data width, FIFO
//            depth, receive-silence timeout length).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int unsigned C_DATA_WIDTH     = 8;
  localparam int unsigned C_FIFO_DEPTH     = 16;
  localparam int unsigned C_TIMEOUT_CYCLES = 4096;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_sync_edge.sv
// ============================================================================
// Module   : uart_sync_edge
// Brief    : Two-flop synchroniser plus rising-edge detector; emits a single
//            clk-wide pulse per rising edge of an asynchronous level.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_sync_edge (
  input  logic clk,
  input  logic rstn,
  input  logic i_async,
  output logic o_pulse
);

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic r_live;
  logic r_armed;

  // r_armed only rises once a genuine low has been sampled after reset, so a
  // level that is already high at reset release never produces a pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_live  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_s1   <= i_async;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_live <= 1'b1;
      if (r_live && !r_s1) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign o_pulse = r_s2 & ~r_s3 & r_armed;

endmodule : uart_sync_edge

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Captures UART receiver bytes into a circular FIFO drained over a
//            valid/ready stream. Optional receive-silence timeout is built when
//            UART_RX_FIFO_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = C_DATA_WIDTH,
  parameter int DEPTH          = C_FIFO_DEPTH,
  parameter int ADDR_WIDTH     = $clog2(DEPTH)
`ifdef UART_RX_FIFO_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = C_TIMEOUT_CYCLES
`endif
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] rx_data_i,
  input  logic                  rx_done_i,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic                  overflow,
  input  logic                  ovf_clr
`ifdef UART_RX_FIFO_TIMEOUT_EN
  ,
  output logic                  timeout
`endif
);

  localparam logic [ADDR_WIDTH:0]   c_depth   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   c_lvl_one = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] c_ptr_one = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_level;
  logic                  r_overflow;

  logic w_push_evt;
  logic w_pop;
  logic w_wr;
  logic w_drop;

  uart_sync_edge u_sync_done (
    .clk     (clk),
    .rstn    (rstn),
    .i_async (rx_done_i),
    .o_pulse (w_push_evt)
  );

  assign m_valid = (r_level != '0);
  assign full    = (r_level == c_depth);
  assign w_pop   = m_valid & m_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO proceeds.
  assign w_wr    = w_push_evt & (~full | w_pop);
  assign w_drop  = w_push_evt & full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= rx_data_i;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + c_lvl_one;
        2'b01:   r_level <= r_level - c_lvl_one;
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign m_data   = m_valid ? r_mem[r_rd_ptr] : '0;
  assign level    = r_level;
  assign overflow = r_overflow;

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int                 c_to_width = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [c_to_width-1:0] c_to_max = c_to_width'(TIMEOUT_CYCLES);
  localparam logic [c_to_width-1:0] c_to_one = c_to_width'(1);

  logic [c_to_width-1:0] r_to_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_to_cnt <= '0;
    end else if (w_push_evt || !m_valid) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != c_to_max) begin
      r_to_cnt <= r_to_cnt + c_to_one;
    end
  end

  assign timeout = (r_to_cnt == c_to_max) && m_valid;
`endif

endmodule : uart_rx_fifo

`default_nettype wire
